pit_ram_arbiter: RTL and testbench
==================================

PIT_RAM_ARBITER -- requirements
Module: pit_ram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, RAM entry address and byte-offset width.
REQ-002 SHALL have parameter DATA_W, default 8, RAM data width.
REQ-003 SHALL have parameter MAX_BURST, default 32, maximum consecutive locked access cycles while the other requester waits.
REQ-004 SHALL have port clk  in  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have ports req_p / req_s  in  1  access request from PIT (p) and SPI-MCU readback (s).
REQ-007 SHALL have ports lock_p / lock_s  in  1  hold ownership for a burst.
REQ-008 SHALL have ports we_p / we_s  in  1  write (1) or read (0).
REQ-009 SHALL have ports addr_p / addr_s  in  ADDR_W  entry address.
REQ-010 SHALL have ports byte_p / byte_s  in  ADDR_W  byte offset.
REQ-011 SHALL have ports wdata_p / wdata_s  in  DATA_W  write data.
REQ-012 SHALL have ports gnt_p / gnt_s  out  1  registered ownership; an access occurs in any cycle where req_x and gnt_x are both high.
REQ-013 SHALL have ports rd_valid_p / rd_valid_s  out  1  read data valid for that requester.
REQ-014 SHALL have port rd_data  out  DATA_W  read data, shared by both requesters.
REQ-015 SHALL have ports ram_addr / ram_byte  out  ADDR_W, ram_wdata  out  DATA_W, ram_we  out  1  to single-port RAM.
REQ-016 SHALL have port ram_q  in  DATA_W  RAM read data, valid one cycle after the address.

Function
REQ-017 SHALL implement an FSM with states IDLE, OWN_P and OWN_S; gnt_p = (state==OWN_P), gnt_s = (state==OWN_S).
REQ-018 IDLE: no request -> IDLE; one request -> that owner; both -> per arbitration policy (REQ-025); grant appears the cycle after req is first sampled.
REQ-019 OWN_x, next state evaluated each cycle:
 - req_x && lock_x && hold_cnt < MAX_BURST-1 -> OWN_x.
 - else other requester's req high -> OWN_other.
 - else req_x high -> OWN_x.
 - else -> IDLE.
REQ-020 lock_x SHALL be ignored while req_x is low.
REQ-021 hold_cnt (width clog2(MAX_BURST)+1) SHALL count accesses in OWN_x, clear on any state change, and saturate at MAX_BURST-1.
REQ-022 RAM ports SHALL be a combinational mux of the owner's addr/byte/wdata during an access; ram_we = owner's we during an access; otherwise all RAM outputs SHALL be 0.
REQ-023 A read access by x in cycle N SHALL assert rd_valid_x for exactly cycle N+1 with rd_data = ram_q; rd_data SHALL be 0 when neither rd_valid is high.
REQ-024 Writes SHALL produce no rd_valid; back-to-back reads SHALL give rd_valid high on consecutive cycles (throughput 1/cycle).
REQ-025 Without the macro, both-requesting ties SHALL go to the requester not served most recently; the last_served register SHALL reset to s, so p wins the first tie.

Reset
REQ-026 rst SHALL force state IDLE, hold_cnt 0, last_served s, and all outputs 0.
REQ-027 rst asserted mid-burst SHALL abort it: no RAM write that cycle, and no rd_valid in the following cycle for a read issued in the reset cycle.

Configuration
REQ-028 Macro NDN_RAM_ARB_FIXED_PRIO_EN, when defined, SHALL make ties always resolve to PIT and SHALL disable the MAX_BURST forced release for a locked PIT owner.
REQ-029 With NDN_RAM_ARB_FIXED_PRIO_EN undefined, REQ-019 and REQ-025 SHALL apply unchanged to both requesters.

Verification
REQ-030 Single write: req_p=1, we_p=1, addr_p=5, byte_p=3, wdata_p=0xA5 -> gnt_p next cycle; that cycle ram_we=1, ram_addr=5, ram_byte=3, ram_wdata=0xA5.
REQ-031 Read latency: s reads addr 7 byte 0 (RAM holds 0x3C) -> rd_valid_s=1 and rd_data=0x3C exactly one cycle after the access; rd_valid_p stays 0.
REQ-032 Round-robin: req_p and req_s held high, unlocked -> grants alternate p,s,p,s from reset; each has one access per cycle in its grant.
REQ-033 Burst limit: p locked, s requesting, MAX_BURST=32 -> exactly 32 p accesses, then gnt_s; with NDN_RAM_ARB_FIXED_PRIO_EN defined, p keeps the grant indefinitely.
REQ-034 Reset mid-burst: rst asserted during the 5th locked p read -> next cycle all outputs 0, state IDLE, no rd_valid.

Source files
------------

// File: rtl/pit_ram_arbiter_if.sv
// Bus bundle between the PIT / SPI-MCU requesters, the arbiter and the
// single-port RAM. The slave modport is the arbiter's view.
interface pit_ram_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
);
  logic              req_p;
  logic              req_s;
  logic              lock_p;
  logic              lock_s;
  logic              we_p;
  logic              we_s;
  logic [ADDR_W-1:0] addr_p;
  logic [ADDR_W-1:0] addr_s;
  logic [ADDR_W-1:0] byte_p;
  logic [ADDR_W-1:0] byte_s;
  logic [DATA_W-1:0] wdata_p;
  logic [DATA_W-1:0] wdata_s;
  logic              gnt_p;
  logic              gnt_s;
  logic              rd_valid_p;
  logic              rd_valid_s;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W-1:0] ram_addr;
  logic [ADDR_W-1:0] ram_byte;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_we;
  logic [DATA_W-1:0] ram_q;

  modport slave (
    input  req_p, req_s, lock_p, lock_s, we_p, we_s,
    input  addr_p, addr_s, byte_p, byte_s, wdata_p, wdata_s, ram_q,
    output gnt_p, gnt_s, rd_valid_p, rd_valid_s, rd_data,
    output ram_addr, ram_byte, ram_wdata, ram_we
  );

  modport master (
    output req_p, req_s, lock_p, lock_s, we_p, we_s,
    output addr_p, addr_s, byte_p, byte_s, wdata_p, wdata_s, ram_q,
    input  gnt_p, gnt_s, rd_valid_p, rd_valid_s, rd_data,
    input  ram_addr, ram_byte, ram_wdata, ram_we
  );
endinterface

// File: rtl/pit_ram_arbiter.sv
// Two-requester arbiter (PIT, SPI-MCU readback) for one single-port RAM.
// Optional macro NDN_RAM_ARB_FIXED_PRIO_EN: PIT wins ties, PIT lock has no burst limit.
module pit_ram_arbiter #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 32
) (
  input logic              clk,
  input logic              rst,
  pit_ram_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(MAX_BURST) + 1;
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_P = 2'd1,
    OWN_S = 2'd2
  } state_t;

  state_t            state_r;
  state_t            next_state_s;
  logic [CNT_W-1:0]  hold_cnt_r;
  logic              last_s_r;
  logic              gnt_p_r;
  logic              gnt_s_r;
  logic              rd_valid_p_r;
  logic              rd_valid_s_r;
  logic              acc_p_s;
  logic              acc_s_s;
  logic              tie_to_p_s;
  logic              hold_p_ok_s;
  logic              hold_s_ok_s;
  logic [ADDR_W-1:0] ram_addr_s;
  logic [ADDR_W-1:0] ram_byte_s;
  logic [DATA_W-1:0] ram_wdata_s;
  logic              ram_we_s;
  logic [DATA_W-1:0] rd_data_s;

  // A reset cycle never counts as an access, so nothing reaches the RAM.
  assign acc_p_s = bus.req_p & gnt_p_r & ~rst;
  assign acc_s_s = bus.req_s & gnt_s_r & ~rst;

  // Tie-break and burst-limit qualifiers.
  always_comb begin
    hold_s_ok_s = (hold_cnt_r < HOLD_MAX);
`ifdef NDN_RAM_ARB_FIXED_PRIO_EN
    tie_to_p_s  = 1'b1;
    hold_p_ok_s = 1'b1;
`else
    tie_to_p_s  = last_s_r;
    hold_p_ok_s = (hold_cnt_r < HOLD_MAX);
`endif
  end

  // Next-state decode.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.req_p && bus.req_s) begin
          next_state_s = tie_to_p_s ? OWN_P : OWN_S;
        end else if (bus.req_p) begin
          next_state_s = OWN_P;
        end else if (bus.req_s) begin
          next_state_s = OWN_S;
        end else begin
          next_state_s = IDLE;
        end
      end
      OWN_P: begin
        if (bus.req_p && bus.lock_p && hold_p_ok_s) begin
          next_state_s = OWN_P;
        end else if (bus.req_s) begin
          next_state_s = OWN_S;
        end else if (bus.req_p) begin
          next_state_s = OWN_P;
        end else begin
          next_state_s = IDLE;
        end
      end
      OWN_S: begin
        if (bus.req_s && bus.lock_s && hold_s_ok_s) begin
          next_state_s = OWN_S;
        end else if (bus.req_p) begin
          next_state_s = OWN_P;
        end else if (bus.req_s) begin
          next_state_s = OWN_S;
        end else begin
          next_state_s = IDLE;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Ownership FSM with registered grants, hold counter and read-valid pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      hold_cnt_r   <= '0;
      last_s_r     <= 1'b1;
      gnt_p_r      <= 1'b0;
      gnt_s_r      <= 1'b0;
      rd_valid_p_r <= 1'b0;
      rd_valid_s_r <= 1'b0;
    end else begin
      state_r <= next_state_s;
      gnt_p_r <= (next_state_s == OWN_P);
      gnt_s_r <= (next_state_s == OWN_S);

      if (next_state_s != state_r) begin
        hold_cnt_r <= '0;
      end else if ((acc_p_s || acc_s_s) && (hold_cnt_r < HOLD_MAX)) begin
        hold_cnt_r <= hold_cnt_r + CNT_W'(1);
      end else begin
        hold_cnt_r <= hold_cnt_r;
      end

      // Served-most-recently is recorded when ownership is handed over.
      if ((next_state_s == OWN_P) && (state_r != OWN_P)) begin
        last_s_r <= 1'b0;
      end else if ((next_state_s == OWN_S) && (state_r != OWN_S)) begin
        last_s_r <= 1'b1;
      end else begin
        last_s_r <= last_s_r;
      end

      rd_valid_p_r <= acc_p_s & ~bus.we_p;
      rd_valid_s_r <= acc_s_s & ~bus.we_s;
    end
  end

  // RAM port mux: owner's fields during an access, zero otherwise.
  always_comb begin
    ram_addr_s  = '0;
    ram_byte_s  = '0;
    ram_wdata_s = '0;
    ram_we_s    = 1'b0;
    if (acc_p_s) begin
      ram_addr_s  = bus.addr_p;
      ram_byte_s  = bus.byte_p;
      ram_wdata_s = bus.wdata_p;
      ram_we_s    = bus.we_p;
    end else if (acc_s_s) begin
      ram_addr_s  = bus.addr_s;
      ram_byte_s  = bus.byte_s;
      ram_wdata_s = bus.wdata_s;
      ram_we_s    = bus.we_s;
    end else begin
      ram_we_s    = 1'b0;
    end
  end

  // Shared read data is forced to zero outside a valid cycle.
  always_comb begin
    rd_data_s = '0;
    if (rd_valid_p_r || rd_valid_s_r) begin
      rd_data_s = bus.ram_q;
    end else begin
      rd_data_s = '0;
    end
  end

  assign bus.gnt_p      = gnt_p_r;
  assign bus.gnt_s      = gnt_s_r;
  assign bus.rd_valid_p = rd_valid_p_r;
  assign bus.rd_valid_s = rd_valid_s_r;
  assign bus.rd_data    = rd_data_s;
  assign bus.ram_addr   = ram_addr_s;
  assign bus.ram_byte   = ram_byte_s;
  assign bus.ram_wdata  = ram_wdata_s;
  assign bus.ram_we     = ram_we_s;

endmodule

// File: tb/tb_pit_ram_arbiter.sv
// Self-checking bench for pit_ram_arbiter: vector table plus hand-written
// round-robin, burst-limit and reset-abort sequences; reads go through a scoreboard.
module tb_pit_ram_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pit_ram_arbiter_if #(.ADDR_W(10), .DATA_W(8)) bus ();

  pit_ram_arbiter #(.ADDR_W(10), .DATA_W(8), .MAX_BURST(32)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Behavioural single-port RAM: registered read, one cycle latency.
  logic [7:0] mem [0:1023];
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    bus.ram_q <= mem[bus.ram_addr];
  end

  typedef struct {
    logic       rp, wp;
    logic [9:0] ap, bp;
    logic [7:0] dp;
    logic       rs, ws;
    logic [9:0] a_s, b_s;
    logic [7:0] d_s;
    logic       gp, gs, ewe;
    logic [9:0] ea, eb;
    logic [7:0] ed;
  } vec_t;

  typedef struct {
    logic       who;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t       sb [$];
  logic [7:0] ref_mem [0:1023];
  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  function automatic vec_t mk(input int rp, wp, ap, bp, dp, rs, ws, a_s, b_s, d_s,
                              input int gp, gs, ewe, ea, eb, ed);
    vec_t v;
    v.rp = 1'(rp);  v.wp = 1'(wp);  v.ap = 10'(ap);   v.bp = 10'(bp);   v.dp = 8'(dp);
    v.rs = 1'(rs);  v.ws = 1'(ws);  v.a_s = 10'(a_s); v.b_s = 10'(b_s); v.d_s = 8'(d_s);
    v.gp = 1'(gp);  v.gs = 1'(gs);  v.ewe = 1'(ewe);
    v.ea = 10'(ea); v.eb = 10'(eb); v.ed = 8'(ed);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic who, input logic [7:0] data);
    exp_t e;
    e.who = who; e.data = data; e.cyc = cyc + 1;
    sb.push_back(e);
  endtask

  // Scoreboard monitor: every expected read must show up exactly on its cycle.
  task automatic monitor();
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      tests++; fails++;
      $display("FAIL rd_missing: got no rd_valid expected data %0h at cycle %0d", sb[0].data, sb[0].cyc);
      e = sb.pop_front();
    end
    if (bus.rd_valid_p || bus.rd_valid_s) begin
      if (sb.size() == 0 || sb[0].cyc != cyc) begin
        tests++; fails++;
        $display("FAIL rd_spurious: got rd_valid_p=%0b rd_valid_s=%0b expected none (cycle %0d)",
                 bus.rd_valid_p, bus.rd_valid_s, cyc);
      end else begin
        e = sb.pop_front();
        chk("rd_valid_p", 32'(bus.rd_valid_p), 32'(!e.who));
        chk("rd_valid_s", 32'(bus.rd_valid_s), 32'(e.who));
        chk("rd_data", 32'(bus.rd_data), 32'(e.data));
      end
    end else begin
      chk("rd_data_idle", 32'(bus.rd_data), 32'd0);
    end
  endtask

  task automatic sample();
    @(negedge clk);
    monitor();
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_inputs();
    bus.req_p = 1'b0; bus.lock_p = 1'b0; bus.we_p = 1'b0;
    bus.addr_p = 10'd0; bus.byte_p = 10'd0; bus.wdata_p = 8'd0;
    bus.req_s = 1'b0; bus.lock_s = 1'b0; bus.we_s = 1'b0;
    bus.addr_s = 10'd0; bus.byte_s = 10'd0; bus.wdata_s = 8'd0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    advance();
    advance();
    @(negedge clk);
    chk("rst_gnt_p", 32'(bus.gnt_p), 32'd0);
    chk("rst_gnt_s", 32'(bus.gnt_s), 32'd0);
    chk("rst_rd_valid", 32'({bus.rd_valid_p, bus.rd_valid_s}), 32'd0);
    chk("rst_ram_we", 32'(bus.ram_we), 32'd0);
    @(posedge clk);
    #1;
    cyc++;
    rst = 1'b0;
  endtask

  task automatic drain(input int n);
    clear_inputs();
    for (int k = 0; k < n; k++) begin
      sample();
      advance();
    end
  endtask

  vec_t vecs [13];
  int   pc;
  logic got_s;

  initial begin
    rst = 1'b1;
    clear_inputs();
    bus.ram_q = 8'd0;

    //          rp wp ap bp dp     rs ws as bs ds     gp gs we ea eb ed
    vecs[0]  = mk(0, 0, 0, 0, 0,     0, 0, 0, 0, 0,     0, 0, 0, 0, 0, 0);
    vecs[1]  = mk(1, 1, 5, 3, 'hA5,  0, 0, 0, 0, 0,     0, 0, 0, 0, 0, 0);
    vecs[2]  = mk(1, 1, 5, 3, 'hA5,  0, 0, 0, 0, 0,     1, 0, 1, 5, 3, 'hA5);
    vecs[3]  = mk(0, 0, 0, 0, 0,     1, 1, 7, 0, 'h3C,  1, 0, 0, 0, 0, 0);
    vecs[4]  = mk(0, 0, 0, 0, 0,     1, 1, 7, 0, 'h3C,  0, 1, 1, 7, 0, 'h3C);
    vecs[5]  = mk(0, 0, 0, 0, 0,     1, 0, 7, 0, 0,     0, 1, 0, 7, 0, 0);
    vecs[6]  = mk(0, 0, 0, 0, 0,     0, 0, 0, 0, 0,     0, 1, 0, 0, 0, 0);
    vecs[7]  = mk(1, 0, 5, 0, 0,     1, 0, 7, 0, 0,     0, 0, 0, 0, 0, 0);
    vecs[8]  = mk(1, 0, 5, 0, 0,     1, 0, 7, 0, 0,     1, 0, 0, 5, 0, 0);
    vecs[9]  = mk(1, 0, 5, 0, 0,     1, 0, 7, 0, 0,     0, 1, 0, 7, 0, 0);
    vecs[10] = mk(1, 0, 5, 0, 0,     1, 0, 7, 0, 0,     1, 0, 0, 5, 0, 0);
    vecs[11] = mk(0, 0, 0, 0, 0,     0, 0, 0, 0, 0,     0, 1, 0, 0, 0, 0);
    vecs[12] = mk(0, 0, 0, 0, 0,     0, 0, 0, 0, 0,     0, 0, 0, 0, 0, 0);

    do_reset();

    // Table-driven sequence from reset.
    for (int i = 0; i < 13; i++) begin
      bus.req_p = vecs[i].rp; bus.we_p = vecs[i].wp; bus.addr_p = vecs[i].ap;
      bus.byte_p = vecs[i].bp; bus.wdata_p = vecs[i].dp;
      bus.req_s = vecs[i].rs; bus.we_s = vecs[i].ws; bus.addr_s = vecs[i].a_s;
      bus.byte_s = vecs[i].b_s; bus.wdata_s = vecs[i].d_s;
      sample();
      chk($sformatf("v%0d_gnt_p", i), 32'(bus.gnt_p), 32'(vecs[i].gp));
      chk($sformatf("v%0d_gnt_s", i), 32'(bus.gnt_s), 32'(vecs[i].gs));
      chk($sformatf("v%0d_ram_we", i), 32'(bus.ram_we), 32'(vecs[i].ewe));
      chk($sformatf("v%0d_ram_addr", i), 32'(bus.ram_addr), 32'(vecs[i].ea));
      chk($sformatf("v%0d_ram_byte", i), 32'(bus.ram_byte), 32'(vecs[i].eb));
      chk($sformatf("v%0d_ram_wdata", i), 32'(bus.ram_wdata), 32'(vecs[i].ed));
      if (vecs[i].gp && vecs[i].rp) begin
        if (vecs[i].wp) ref_mem[vecs[i].ap] = vecs[i].dp;
        else            push(1'b0, ref_mem[vecs[i].ap]);
      end
      if (vecs[i].gs && vecs[i].rs) begin
        if (vecs[i].ws) ref_mem[vecs[i].a_s] = vecs[i].d_s;
        else            push(1'b1, ref_mem[vecs[i].a_s]);
      end
      advance();
    end
    drain(2);

    // Round robin from reset: p wins the first tie, then strict alternation.
    do_reset();
    bus.req_p = 1'b1; bus.addr_p = 10'd5;
    bus.req_s = 1'b1; bus.addr_s = 10'd7;
    for (int i = 0; i < 6; i++) begin
      sample();
      chk($sformatf("rr%0d_gnt_p", i), 32'(bus.gnt_p), 32'((i % 2) == 1));
      chk($sformatf("rr%0d_gnt_s", i), 32'(bus.gnt_s), 32'((i > 0) && ((i % 2) == 0)));
      if (i > 0) chk($sformatf("rr%0d_ram_addr", i), 32'(bus.ram_addr), (i % 2) == 1 ? 32'd5 : 32'd7);
      if (i > 0) push((i % 2) == 0, (i % 2) == 1 ? ref_mem[5] : ref_mem[7]);
      advance();
    end
    drain(2);

    // Locked p burst against a waiting s requester.
    do_reset();
    bus.req_p = 1'b1; bus.lock_p = 1'b1; bus.addr_p = 10'd5;
    bus.req_s = 1'b1; bus.addr_s = 10'd7;
    pc = 0;
    got_s = 1'b0;
    for (int i = 0; i < 80 && !got_s; i++) begin
      sample();
      if (bus.gnt_p) begin
        pc++;
        push(1'b0, ref_mem[5]);
      end
      if (bus.gnt_s) begin
        got_s = 1'b1;
        push(1'b1, ref_mem[7]);
      end
      advance();
    end
`ifdef NDN_RAM_ARB_FIXED_PRIO_EN
    chk("burst_gnt_s_seen", 32'(got_s), 32'd0);
    chk("burst_p_count", 32'(pc), 32'd79);
`else
    if (!got_s) $display("FAIL burst_timeout: got no gnt_s within 80 cycles expected gnt_s after 32 p accesses");
    chk("burst_gnt_s_seen", 32'(got_s), 32'd1);
    chk("burst_p_count", 32'(pc), 32'd32);
`endif
    drain(2);

    // Reset during the 5th locked p read aborts it.
    do_reset();
    bus.req_p = 1'b1; bus.lock_p = 1'b1; bus.addr_p = 10'd5;
    for (int i = 0; i < 5; i++) begin
      sample();
      chk($sformatf("rb%0d_gnt_p", i), 32'(bus.gnt_p), 32'(i > 0));
      if (i > 0) push(1'b0, ref_mem[5]);
      advance();
    end
    rst = 1'b1;
    sample();
    chk("rb_rstcyc_gnt_p", 32'(bus.gnt_p), 32'd1);
    chk("rb_rstcyc_ram_we", 32'(bus.ram_we), 32'd0);
    advance();
    rst = 1'b0;
    clear_inputs();
    sample();
    chk("rb_after_gnt", 32'({bus.gnt_p, bus.gnt_s}), 32'd0);
    chk("rb_after_rd_valid", 32'({bus.rd_valid_p, bus.rd_valid_s}), 32'd0);
    chk("rb_after_rd_data", 32'(bus.rd_data), 32'd0);
    chk("rb_after_ram", 32'({bus.ram_we, bus.ram_addr, bus.ram_wdata}), 32'd0);
    advance();
    drain(2);

    // Reset during a write access blocks the RAM write.
    do_reset();
    bus.req_p = 1'b1; bus.we_p = 1'b1; bus.addr_p = 10'd9; bus.wdata_p = 8'h66;
    sample();
    advance();
    sample();
    chk("wr_ram_we", 32'(bus.ram_we), 32'd1);
    chk("wr_ram_wdata", 32'(bus.ram_wdata), 32'h66);
    advance();
    rst = 1'b1;
    bus.wdata_p = 8'h77;
    sample();
    chk("wr_rstcyc_ram_we", 32'(bus.ram_we), 32'd0);
    advance();
    rst = 1'b0;
    drain(2);
    chk("wr_abort_mem", 32'(mem[9]), 32'h66);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
